coffee_controller: RTL and testbench
====================================

# coffee_controller

Main sequencing FSM of the coffee machine. It takes drink-select buttons, coin strobes, a confirm/cancel pair and three supply-sensor fault inputs. It produces the registered status flags (S0–S3, SR, SP, SN, VL, M) consumed by the 7-segment display decoder stage directly downstream. It also accumulates credit, times the brew and returns change.

## Interface
Parameters:
- PRICE0, 1: price of drink 0 (CE01), in credit units
- PRICE1, 2: price of drink 1 (CL02)
- PRICE2, 5: price of drink 2 (CC05)
- PRICE3, 10: price of drink 3 (CP10)
- BREW_CYCLES, 16: clock cycles spent in BREW (≥1)
- ERR_HOLD, 8: clock cycles an error flag is held (≥1)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- BTN  in  4  drink-select buttons, level, bit i = drink i
- COIN  in  4  value of the inserted coin, sampled when COIN_V=1
- COIN_V  in  1  one-cycle coin strobe
- CONFIRM  in  1  one-cycle start-order pulse
- CANCEL  in  1  one-cycle abort pulse
- FLT_R, FLT_P, FLT_N  in  1 each  sensor faults, active-high: reservoir, powder, nozzle
- S0, S1, S2, S3  out  1 each  selected drink, one-hot
- SR, SP, SN  out  1 each  sensor error flags
- VL  out  1  insufficient-credit error flag
- M  out  1  brewing indicator; drives the display decimal point
- CHANGE  out  5  change/refund amount, valid with CHG_V
- CHG_V  out  1  one-cycle change strobe

## Operation
- States: IDLE, SELECT, BREW, ERR_SENS, ERR_VAL.
- Credit register is 5 bits. Coin addition saturates at 31.
- Output exclusivity: at most one of S0–S3/SR/SP/SN/VL is high in any cycle. All of them low is the display's wait mode.
- IDLE:
  - All flags low and credit = 0.
  - When BTN has exactly one bit set, latch the selection and go to SELECT.
  - When BTN has zero or multiple bits set, stay in IDLE.
  - Coins are ignored in IDLE.
- SELECT:
  - S<sel> is high.
  - COIN_V adds COIN to credit. A different single BTN bit re-latches the selection.
  - CANCEL takes priority over CONFIRM in the same cycle. On CANCEL: if credit > 0, pulse CHANGE=credit with CHG_V; then go to IDLE.
  - CONFIRM checks faults in priority FLT_R > FLT_P > FLT_N. The first active fault raises SR, SP or SN respectively and goes to ERR_SENS.
  - With no fault active, CONFIRM with credit < price goes to ERR_VAL.
  - Otherwise CONFIRM subtracts the price from credit and goes to BREW.
  - COIN_V coinciding with CONFIRM is added before the credit comparison.
- BREW:
  - M=1 and S<sel> stays high. Counter runs from BREW_CYCLES-1 down to 0.
  - BTN, COIN_V, CONFIRM and CANCEL are ignored.
  - Any fault mid-brew aborts to ERR_SENS (same priority). Remaining credit is refunded; the paid price is not.
  - On counter 0: if remaining credit > 0, pulse CHANGE/CHG_V; clear credit; go to IDLE.
- ERR_SENS:
  - The chosen SR/SP/SN flag is held for ERR_HOLD cycles, and S flags are low.
  - CHG_V pulses on the entry cycle if credit > 0, and credit is cleared.
  - Then go to IDLE, regardless of the current fault level.
- ERR_VAL:
  - VL is held for ERR_HOLD cycles, with S flags low and credit retained.
  - Then return to SELECT with the same selection.

## Timing
- Every output is registered. A transition triggered by an input at edge k is visible on the outputs after edge k.
- Reset values: state = IDLE, and every output and register is 0: S0–S3, SR, SP, SN, VL, M, CHANGE, CHG_V, credit, counters and selection.
- RST asserted mid-BREW or in an error state clears everything immediately, with no change pulse.
- CHG_V is high for exactly one cycle. CHANGE holds its value only in that cycle and is 0 otherwise.
- BREW lasts exactly BREW_CYCLES cycles with M=1. M falls in the same cycle CHG_V pulses.
- Error flags are high for exactly ERR_HOLD cycles.
- Button-to-flag latency is 1 cycle. Confirm-to-M latency is 1 cycle.

## Test plan
- Reset, then BTN=0010, coins 1 and 1, CONFIRM. Required: S1 high, then M high for 16 cycles, then IDLE with no CHG_V (credit = price).
- Select drink 3, coin 15, CONFIRM. Required: after 16 brew cycles, CHG_V with CHANGE=5, then all flags 0.
- Select drink 2, coin 3, CONFIRM. Required: VL high for 8 cycles with S2 low; then S2 returns with credit 3. Then coin 2 and CONFIRM: BREW with no change.
- FLT_P=1 and FLT_N=1 at CONFIRM with credit 4 on drink 0. Required: SP only for 8 cycles, CHG_V with CHANGE=4, then IDLE.
- FLT_R raised on cycle 5 of BREW with drink 1 and credit 7. Required: M drops, SR high for 8 cycles, CHANGE=5. Separately, RST mid-BREW: all outputs 0 next cycle.
- Boundary cases:
  - BTN=0110 in IDLE: no selection.
  - Coins summing to 40: credit saturates at 31.
  - CANCEL and CONFIRM in the same cycle with credit 6: CHANGE=6, IDLE, no BREW.

Source files
------------

// File: rtl/coffee_controller.sv
// coffee_controller: coffee machine sequencing FSM with credit, brew timer, change.
// Ports: CLK/RST, BTN, COIN/COIN_V, CONFIRM/CANCEL, FLT_R/P/N -> S0-S3, SR/SP/SN, VL, M, CHANGE/CHG_V.
module coffee_controller #(
  parameter int PRICE0      = 1,
  parameter int PRICE1      = 2,
  parameter int PRICE2      = 5,
  parameter int PRICE3      = 10,
  parameter int BREW_CYCLES = 16,
  parameter int ERR_HOLD    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic [3:0] COIN,
  input  logic       COIN_V,
  input  logic       CONFIRM,
  input  logic       CANCEL,
  input  logic       FLT_R,
  input  logic       FLT_P,
  input  logic       FLT_N,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       SR,
  output logic       SP,
  output logic       SN,
  output logic       VL,
  output logic       M,
  output logic [4:0] CHANGE,
  output logic       CHG_V
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    BREW,
    ERR_SENS,
    ERR_VAL
  } state_t;

  localparam int MAXC = (BREW_CYCLES > ERR_HOLD) ? BREW_CYCLES : ERR_HOLD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BREW_LD = CW'(BREW_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(ERR_HOLD - 1);

  state_t        state;
  logic [1:0]    sel;
  logic [4:0]    credit;
  logic [CW-1:0] cnt;
  logic [3:0]    s_q;
  logic [2:0]    e_q;

  logic          btn_one;
  logic [1:0]    btn_idx;
  logic [5:0]    sum;
  logic [4:0]    coin_credit;
  logic [4:0]    price;
  logic          fault_any;
  logic [2:0]    fault_code;

  function automatic logic [3:0] dec(input logic [1:0] i);
    dec = 4'b0001 << i;
  endfunction

  always_comb begin
    btn_one = 1'b0;
    btn_idx = 2'd0;
    case (BTN)
      4'b0001: begin btn_one = 1'b1; btn_idx = 2'd0; end
      4'b0010: begin btn_one = 1'b1; btn_idx = 2'd1; end
      4'b0100: begin btn_one = 1'b1; btn_idx = 2'd2; end
      4'b1000: begin btn_one = 1'b1; btn_idx = 2'd3; end
      default: ;
    endcase
  end

  // Coin value folded into credit, saturating at 31.
  always_comb begin
    sum = {1'b0, credit} + {2'b00, COIN};
    coin_credit = credit;
    if (COIN_V) coin_credit = sum[5] ? 5'd31 : sum[4:0];
  end

  always_comb begin
    price = 5'(PRICE0);
    case (sel)
      2'd0: price = 5'(PRICE0);
      2'd1: price = 5'(PRICE1);
      2'd2: price = 5'(PRICE2);
      2'd3: price = 5'(PRICE3);
      default: ;
    endcase
  end

  // Fault priority reservoir > powder > nozzle, encoded as {SR,SP,SN}.
  always_comb begin
    fault_any  = FLT_R | FLT_P | FLT_N;
    fault_code = 3'b000;
    if (FLT_R)      fault_code = 3'b100;
    else if (FLT_P) fault_code = 3'b010;
    else if (FLT_N) fault_code = 3'b001;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      sel    <= 2'd0;
      credit <= 5'd0;
      cnt    <= '0;
      s_q    <= 4'd0;
      e_q    <= 3'd0;
      VL     <= 1'b0;
      M      <= 1'b0;
      CHANGE <= 5'd0;
      CHG_V  <= 1'b0;
    end else begin
      CHG_V  <= 1'b0;
      CHANGE <= 5'd0;
      case (state)
        IDLE: begin
          credit <= 5'd0;
          if (btn_one) begin
            sel   <= btn_idx;
            s_q   <= dec(btn_idx);
            state <= SELECT;
          end
        end
        SELECT: begin
          if (CANCEL) begin
            if (coin_credit != 5'd0) begin
              CHG_V  <= 1'b1;
              CHANGE <= coin_credit;
            end
            credit <= 5'd0;
            s_q    <= 4'd0;
            state  <= IDLE;
          end else if (CONFIRM) begin
            if (fault_any) begin
              if (coin_credit != 5'd0) begin
                CHG_V  <= 1'b1;
                CHANGE <= coin_credit;
              end
              credit <= 5'd0;
              e_q    <= fault_code;
              s_q    <= 4'd0;
              cnt    <= HOLD_LD;
              state  <= ERR_SENS;
            end else if (coin_credit < price) begin
              credit <= coin_credit;
              VL     <= 1'b1;
              s_q    <= 4'd0;
              cnt    <= HOLD_LD;
              state  <= ERR_VAL;
            end else begin
              credit <= coin_credit - price;
              M      <= 1'b1;
              cnt    <= BREW_LD;
              state  <= BREW;
            end
          end else begin
            credit <= coin_credit;
            if (btn_one) begin
              sel <= btn_idx;
              s_q <= dec(btn_idx);
            end
          end
        end
        BREW: begin
          // Fault aborts the brew; leftover credit is refunded, price is kept.
          if (fault_any || cnt == '0) begin
            if (credit != 5'd0) begin
              CHG_V  <= 1'b1;
              CHANGE <= credit;
            end
            credit <= 5'd0;
            M      <= 1'b0;
            s_q    <= 4'd0;
            if (fault_any) begin
              e_q   <= fault_code;
              cnt   <= HOLD_LD;
              state <= ERR_SENS;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ERR_SENS: begin
          if (cnt == '0) begin
            e_q   <= 3'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ERR_VAL: begin
          if (cnt == '0) begin
            VL    <= 1'b0;
            s_q   <= dec(sel);
            state <= SELECT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign S0 = s_q[0];
  assign S1 = s_q[1];
  assign S2 = s_q[2];
  assign S3 = s_q[3];
  assign SR = e_q[2];
  assign SP = e_q[1];
  assign SN = e_q[0];

endmodule

// File: tb/tb_coffee_controller.sv
// tb_coffee_controller: directed self-checking bench for coffee_controller.
// Drives button/coin/confirm/fault sequences and checks flags, change and timing.
module tb_coffee_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BTN = 4'd0;
  logic [3:0] COIN = 4'd0;
  logic       COIN_V = 1'b0;
  logic       CONFIRM = 1'b0;
  logic       CANCEL = 1'b0;
  logic       FLT_R = 1'b0;
  logic       FLT_P = 1'b0;
  logic       FLT_N = 1'b0;
  logic       S0, S1, S2, S3, SR, SP, SN, VL, M;
  logic [4:0] CHANGE;
  logic       CHG_V;

  int checks = 0;
  int failures = 0;

  // Flag vector order {S0,S1,S2,S3,SR,SP,SN,VL,M}
  localparam logic [8:0] F0  = 9'b0_0000_0000;
  localparam logic [8:0] FS0 = 9'b1_0000_0000;
  localparam logic [8:0] FS1 = 9'b0_1000_0000;
  localparam logic [8:0] FS2 = 9'b0_0100_0000;
  localparam logic [8:0] FS3 = 9'b0_0010_0000;
  localparam logic [8:0] FSR = 9'b0_0001_0000;
  localparam logic [8:0] FSP = 9'b0_0000_1000;
  localparam logic [8:0] FVL = 9'b0_0000_0010;
  localparam logic [8:0] FM  = 9'b0_0000_0001;

  coffee_controller dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .COIN(COIN), .COIN_V(COIN_V),
    .CONFIRM(CONFIRM), .CANCEL(CANCEL),
    .FLT_R(FLT_R), .FLT_P(FLT_P), .FLT_N(FLT_N),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3),
    .SR(SR), .SP(SP), .SN(SN), .VL(VL), .M(M),
    .CHANGE(CHANGE), .CHG_V(CHG_V)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] flags();
    flags = {S0, S1, S2, S3, SR, SP, SN, VL, M};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [3:0] v);
    COIN = v;
    COIN_V = 1'b1;
    tick();
    COIN_V = 1'b0;
    COIN = 4'd0;
  endtask

  task automatic press(input logic [3:0] b);
    BTN = b;
    tick();
    BTN = 4'd0;
  endtask

  task automatic confirm();
    CONFIRM = 1'b1;
    tick();
    CONFIRM = 1'b0;
  endtask

  // Called after the confirm edge with M already checked high (cycle 1).
  task automatic brew_run(input string tag, input logic [4:0] chg);
    int mc = 0;
    int cc = 0;
    repeat (15) begin
      tick();
      mc += int'(M);
      cc += int'(CHG_V);
    end
    chk({tag, "_mlen"}, mc, 15);
    chk({tag, "_chg_early"}, cc, 0);
    tick();
    chk({tag, "_end_flags"}, flags(), F0);
    chk({tag, "_chgv"}, CHG_V, (chg != 0) ? 1 : 0);
    chk({tag, "_change"}, CHANGE, chg);
  endtask

  // Counts cycles a flag pattern is held after its entry cycle.
  task automatic hold_run(input string tag, input logic [8:0] f);
    int hc = 0;
    int cc = 0;
    repeat (7) begin
      tick();
      hc += (flags() == f) ? 1 : 0;
      cc += int'(CHG_V);
    end
    chk({tag, "_hold"}, hc, 7);
    chk({tag, "_chg_once"}, cc, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_flags", flags(), F0);
    chk("rst_change", CHANGE, 0);
    chk("rst_chgv", CHG_V, 0);
    RST = 1'b0;
    tick();

    // Drink 1, exact credit
    press(4'b0010);
    chk("t1_sel", flags(), FS1);
    coin(4'd1);
    coin(4'd1);
    confirm();
    chk("t1_brew", flags(), FS1 | FM);
    brew_run("t1", 5'd0);

    // Drink 3, overpay 15
    press(4'b1000);
    chk("t2_sel", flags(), FS3);
    coin(4'd15);
    confirm();
    chk("t2_brew", flags(), FS3 | FM);
    brew_run("t2", 5'd5);
    tick();
    chk("t2_chg_clear", CHANGE, 0);
    chk("t2_chgv_clear", CHG_V, 0);

    // Drink 2, insufficient then top-up
    press(4'b0100);
    coin(4'd3);
    confirm();
    chk("t3_vl", flags(), FVL);
    hold_run("t3_vl", FVL);
    tick();
    chk("t3_back", flags(), FS2);
    coin(4'd2);
    confirm();
    chk("t3_brew", flags(), FS2 | FM);
    brew_run("t3", 5'd0);

    // Powder and nozzle faults at confirm
    press(4'b0001);
    coin(4'd4);
    FLT_P = 1'b1;
    FLT_N = 1'b1;
    confirm();
    FLT_P = 1'b0;
    FLT_N = 1'b0;
    chk("t4_sp", flags(), FSP);
    chk("t4_chgv", CHG_V, 1);
    chk("t4_change", CHANGE, 4);
    hold_run("t4_sp", FSP);
    tick();
    chk("t4_idle", flags(), F0);

    // Reservoir fault on brew cycle 5
    press(4'b0010);
    coin(4'd7);
    confirm();
    chk("t5_brew", flags(), FS1 | FM);
    repeat (3) tick();
    chk("t5_c4", M, 1);
    FLT_R = 1'b1;
    tick();
    FLT_R = 1'b0;
    chk("t5_sr", flags(), FSR);
    chk("t5_chgv", CHG_V, 1);
    chk("t5_change", CHANGE, 5);
    hold_run("t5_sr", FSR);
    tick();
    chk("t5_idle", flags(), F0);

    // Reset mid-brew
    press(4'b0001);
    coin(4'd3);
    confirm();
    tick();
    tick();
    chk("t6_pre", flags(), FS0 | FM);
    RST = 1'b1;
    #1;
    chk("t6_rst_flags", flags(), F0);
    chk("t6_rst_chgv", CHG_V, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("t6_after", flags(), F0);
    // Credit was wiped: no-coin confirm must fail on value
    press(4'b0001);
    confirm();
    chk("t6_nocredit", flags(), FVL);
    repeat (8) tick();
    chk("t6_resel", flags(), FS0);
    CANCEL = 1'b1;
    tick();
    CANCEL = 1'b0;
    chk("t6_cancel_chgv", CHG_V, 0);
    chk("t6_cancel_idle", flags(), F0);

    // Multi-bit button, idle coins ignored
    BTN = 4'b0110;
    tick();
    tick();
    BTN = 4'd0;
    chk("b1_multi", flags(), F0);
    coin(4'd5);
    press(4'b0001);
    chk("b1_sel0", flags(), FS0);
    press(4'b0100);
    chk("b1_relatch", flags(), FS2);
    CANCEL = 1'b1;
    tick();
    CANCEL = 1'b0;
    chk("b1_idlecoin", CHG_V, 0);

    // Saturation at 31
    press(4'b1000);
    coin(4'd15);
    coin(4'd15);
    coin(4'd10);
    CANCEL = 1'b1;
    tick();
    CANCEL = 1'b0;
    chk("b2_chgv", CHG_V, 1);
    chk("b2_sat", CHANGE, 31);
    chk("b2_idle", flags(), F0);

    // Cancel beats confirm
    press(4'b0010);
    coin(4'd6);
    CANCEL = 1'b1;
    CONFIRM = 1'b1;
    tick();
    CANCEL = 1'b0;
    CONFIRM = 1'b0;
    chk("b3_chgv", CHG_V, 1);
    chk("b3_change", CHANGE, 6);
    chk("b3_flags", flags(), F0);
    tick();
    chk("b3_nobrew", flags(), F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
